// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and constants: packet layout, execution-unit indices and
// the index-width helper used by the arbiter and its interface.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_N_EXU     = 4;
    localparam int unsigned CDB_TAG_W     = 6;
    localparam int unsigned CDB_ROB_PTR_W = 4;
    localparam int unsigned CDB_DATA_W    = 32;

    localparam int unsigned EXU_ALU = 0;
    localparam int unsigned EXU_MDU = 1;
    localparam int unsigned EXU_LSU = 2;
    localparam int unsigned EXU_BRU = 3;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]     tag;
        logic [CDB_ROB_PTR_W-1:0] inst_id;
        logic [CDB_DATA_W-1:0]    wdata;
    } cdb_pkt_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Execution-unit to CDB handshake plus the broadcast bus. The master modport is
// the execution-unit side; the slave modport is the arbiter (CDB) side.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_EXU     = CDB_N_EXU,
    parameter int unsigned TAG_W     = CDB_TAG_W,
    parameter int unsigned ROB_PTR_W = CDB_ROB_PTR_W,
    parameter int unsigned DATA_W    = CDB_DATA_W
);

    localparam int unsigned SRC_W = idx_w(N_EXU);

    logic [N_EXU-1:0]           exu_req;
    logic [N_EXU*TAG_W-1:0]     exu_tag;
    logic [N_EXU*ROB_PTR_W-1:0] exu_inst_id;
    logic [N_EXU*DATA_W-1:0]    exu_wdata;
    logic [N_EXU-1:0]           exu_rdy;

    logic                       cdb_vld;
    logic [TAG_W-1:0]           cdb_tag;
    logic [ROB_PTR_W-1:0]       cdb_inst_id;
    logic [DATA_W-1:0]          cdb_wdata;
    logic [SRC_W-1:0]           cdb_src;

    modport master (
        output exu_req, exu_tag, exu_inst_id, exu_wdata,
        input  exu_rdy,
        input  cdb_vld, cdb_tag, cdb_inst_id, cdb_wdata, cdb_src
    );

    modport slave (
        input  exu_req, exu_tag, exu_inst_id, exu_wdata,
        output exu_rdy,
        output cdb_vld, cdb_tag, cdb_inst_id, cdb_wdata, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: masked priority encoder that prefers
// requesters at or above ptr and falls back to the lowest requester overall.
module rr_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] sel;
    logic         found;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (i >= 32'(ptr));
        end
        masked = req & mask;
        // An empty masked set means every requester sits below ptr: wrap around.
        sel = (|masked) ? masked : req;
    end

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && sel[i]) begin
                found      = 1'b1;
                gnt[i]     = 1'b1;
                gnt_idx    = IDX_W'(i);
            end
        end
        gnt_vld = found;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin accepts one execution-unit result per cycle and
// broadcasts it on the common data bus one cycle later; flush drains all units.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_EXU     = CDB_N_EXU,
    parameter int unsigned TAG_W     = CDB_TAG_W,
    parameter int unsigned ROB_PTR_W = CDB_ROB_PTR_W,
    parameter int unsigned DATA_W    = CDB_DATA_W
) (
    input logic          clk,
    input logic          rst_n,
    input logic          flush,
    cdb_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = idx_w(N_EXU);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             cdb_vld_q, cdb_vld_d;
    cdb_pkt_t         cdb_pkt_q, cdb_pkt_d;
    logic [IDX_W-1:0] cdb_src_q, cdb_src_d;

    logic [N_EXU-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             take;
    cdb_pkt_t         sel_pkt;

    rr_arbiter #(.N(N_EXU)) u_rr (
        .req     (bus.exu_req),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        if (!rst_n) begin
            bus.exu_rdy = '0;
        end else if (flush) begin
            bus.exu_rdy = bus.exu_req;
        end else begin
            bus.exu_rdy = gnt;
        end
    end

    always_comb begin
        sel_pkt = '0;
        for (int unsigned i = 0; i < N_EXU; i++) begin
            if (gnt[i]) begin
                sel_pkt.tag     = bus.exu_tag[i*TAG_W +: TAG_W];
                sel_pkt.inst_id = bus.exu_inst_id[i*ROB_PTR_W +: ROB_PTR_W];
                sel_pkt.wdata   = bus.exu_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        take      = gnt_vld && !flush;
        cdb_vld_d = take;
        rr_ptr_d  = rr_ptr_q;
        cdb_pkt_d = cdb_pkt_q;
        cdb_src_d = cdb_src_q;
        if (take) begin
            rr_ptr_d  = (gnt_idx == IDX_W'(N_EXU - 1)) ? '0 : gnt_idx + IDX_W'(1);
            cdb_pkt_d = sel_pkt;
            cdb_src_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            cdb_vld_q <= 1'b0;
            cdb_pkt_q <= '0;
            cdb_src_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            cdb_vld_q <= cdb_vld_d;
            cdb_pkt_q <= cdb_pkt_d;
            cdb_src_q <= cdb_src_d;
        end
    end

    assign bus.cdb_vld     = cdb_vld_q;
    assign bus.cdb_tag     = cdb_pkt_q.tag;
    assign bus.cdb_inst_id = cdb_pkt_q.inst_id;
    assign bus.cdb_wdata   = cdb_pkt_q.wdata;
    assign bus.cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed plan steps followed by random
// traffic, all compared against a scan-and-queue reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int IW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_EXU(N), .TAG_W(TW), .ROB_PTR_W(IW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.N_EXU(N), .TAG_W(TW), .ROB_PTR_W(IW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Unit-side state: each unit holds its request and payload until accepted.
    logic [N-1:0]  u_req;
    logic [TW-1:0] u_tag  [N];
    logic [IW-1:0] u_id   [N];
    logic [DW-1:0] u_data [N];

    // Reference model of the arbiter's visible state.
    int            m_ptr  = 0;
    logic          m_vld  = 1'b0;
    logic [TW-1:0] m_tag  = '0;
    logic [IW-1:0] m_id   = '0;
    logic [DW-1:0] m_data = '0;
    int            m_src  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.exu_req = u_req;
        for (int i = 0; i < N; i++) begin
            bus.exu_tag[i*TW +: TW]     = u_tag[i];
            bus.exu_inst_id[i*IW +: IW] = u_id[i];
            bus.exu_wdata[i*DW +: DW]   = u_data[i];
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic new_payload(input int i);
        u_req[i]  = 1'b1;
        u_tag[i]  = TW'($urandom);
        u_id[i]   = IW'($urandom);
        u_data[i] = $urandom;
    endtask

    // One clock: check at negedge, advance model, let accepted units move on.
    task automatic cycle(input bit refill);
        logic [N-1:0] exp_rdy;
        int g;
        drive();
        @(negedge clk);
        g = pick(u_req, m_ptr);
        if (!rst_n)      exp_rdy = '0;
        else if (flush)  exp_rdy = u_req;
        else if (g >= 0) exp_rdy = N'(1) << g;
        else             exp_rdy = '0;
        chk("exu_rdy",     64'(bus.exu_rdy),     64'(exp_rdy));
        chk("cdb_vld",     64'(bus.cdb_vld),     64'(m_vld));
        chk("cdb_tag",     64'(bus.cdb_tag),     64'(m_tag));
        chk("cdb_inst_id", 64'(bus.cdb_inst_id), 64'(m_id));
        chk("cdb_wdata",   64'(bus.cdb_wdata),   64'(m_data));
        chk("cdb_src",     64'(bus.cdb_src),     64'(m_src));
        if (!rst_n) begin
            m_ptr = 0; m_vld = 1'b0; m_tag = '0; m_id = '0; m_data = '0; m_src = 0;
            u_req = '0;
        end else if (flush) begin
            m_vld = 1'b0;
        end else if (g >= 0) begin
            m_vld  = 1'b1;
            m_tag  = u_tag[g];
            m_id   = u_id[g];
            m_data = u_data[g];
            m_src  = g;
            m_ptr  = (g + 1) % N;
        end else begin
            m_vld = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                u_req[i] = 1'b0;
                if (refill) new_payload(i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        u_req = '0;
        for (int i = 0; i < N; i++) begin
            u_tag[i] = '0; u_id[i] = '0; u_data[i] = '0;
        end
        drive();
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state and idle bus
        repeat (2) cycle(1'b0);
        rst_n = 1'b1;
        repeat (5) cycle(1'b0);

        // Single MDU requester
        u_req[EXU_MDU]  = 1'b1;
        u_tag[EXU_MDU]  = 6'h0A;
        u_id[EXU_MDU]   = 4'h3;
        u_data[EXU_MDU] = 32'hDEAD_BEEF;
        repeat (3) cycle(1'b0);

        // All four requesting continuously from reset
        rst_n = 1'b0;
        cycle(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            u_req[i]  = 1'b1;
            u_tag[i]  = TW'(6'h10 + i);
            u_id[i]   = IW'(4'h8 + i);
            u_data[i] = 32'hA5A5_0000 + i;
        end
        repeat (6) cycle(1'b1);
        repeat (5) cycle(1'b0);

        // Wrap-around: grant idx2 (ptr -> 3), then idx0 and idx3 compete
        new_payload(2);
        cycle(1'b0);
        new_payload(0);
        new_payload(3);
        repeat (3) cycle(1'b0);

        // Flush with two requesters, then pointer is probed with all requesting
        new_payload(1);
        new_payload(2);
        flush = 1'b1;
        cycle(1'b0);
        flush = 1'b0;
        repeat (2) cycle(1'b0);
        for (int i = 0; i < N; i++) new_payload(i);
        repeat (2) cycle(1'b1);
        repeat (5) cycle(1'b0);

        // Reset the cycle after a grant to idx2
        new_payload(2);
        cycle(1'b0);
        rst_n = 1'b0;
        cycle(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) new_payload(i);
        repeat (3) cycle(1'b1);
        repeat (5) cycle(1'b0);

        // Random traffic with occasional flush and reset
        repeat (400) begin
            flush = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < N; i++) begin
                if (!u_req[i] && $urandom_range(0, 2) == 0) new_payload(i);
            end
            cycle(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Consumer end of the execution-unit-to-CDB handshake: the cdb side of exu2cdb_itf, opposite every execution unit (ALU, MDU, LSU, branch unit).
- Each cycle it selects at most one requesting unit by round-robin arbitration and returns rdy to that unit only.
- It registers the winner's tag, inst_id and wdata, then broadcasts them on the common data bus the next cycle to the reservation stations, register file and ROB.

Parameters:
N_EXU, 4, number of execution units competing for the CDB (index 0 = ALU, 1 = MDU, 2 = LSU, 3 = BRU)
TAG_W, 6, physical destination tag width
ROB_PTR_W, 4, ROB index width (ROB_DEPTH 16)
DATA_W, 32, result width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
flush  input  1  ROB mispredict flush; squash everything in flight
exu_req  input  N_EXU  per-unit result valid (exu2cdb_itf.req)
exu_tag  input  N_EXU*TAG_W  per-unit destination tag
exu_inst_id  input  N_EXU*ROB_PTR_W  per-unit ROB index
exu_wdata  input  N_EXU*DATA_W  per-unit result
exu_rdy  output  N_EXU  per-unit accept (exu2cdb_itf.rdy), one-hot or zero
cdb_vld  output  1  broadcast valid
cdb_tag  output  TAG_W  broadcast tag
cdb_inst_id  output  ROB_PTR_W  broadcast ROB index
cdb_wdata  output  DATA_W  broadcast data
cdb_src  output  $clog2(N_EXU)  index of the unit that produced the broadcast (debug/perf)

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low (rst_n); all state is sampled on posedge clk.
- Reset (rst_n=0):
  - cdb_vld=0; cdb_tag, cdb_inst_id, cdb_wdata and cdb_src = 0.
  - Round-robin pointer rr_ptr=0.
  - exu_rdy is combinational and is forced to 0 while rst_n=0.
- Handshake:
  - A unit holds req and its payload stable until it samples rdy=1.
  - A transfer occurs on any cycle with exu_req[i] && exu_rdy[i].
  - exu_rdy depends combinationally on exu_req; no unit may make req depend on rdy.
- Arbitration:
  - Grant goes to the first requesting index found by scanning rr_ptr, rr_ptr+1, ... N_EXU-1, wrapping to 0.
  - exu_rdy = one-hot of the grant, or 0 if no request.
  - The arbiter never stalls: a grant is always issued whenever any req is high.
- Pointer update:
  - On a grant to index g, rr_ptr <= (g+1) mod N_EXU.
  - With no grant, rr_ptr holds.
- Broadcast latency: exactly 1 cycle. Transfer in cycle t produces cdb_vld=1 with that payload in cycle t+1.
- Back-to-back transfers every cycle are permitted. cdb_vld stays high continuously if requests persist.
- With no transfer, cdb_vld <= 0 and the payload registers hold their old values; consumers must qualify on cdb_vld.
- Flush:
  - While flush=1, exu_rdy = exu_req (all pending results are accepted and discarded so units drain to IDLE).
  - cdb_vld <= 0 and rr_ptr holds.
  - A broadcast already registered when flush rises is still presented that cycle; ROB-side filtering handles it.
- Single requester: it is granted in the same cycle regardless of rr_ptr.
- Reset mid-transfer: the pending broadcast is lost and rr_ptr returns to 0. Units are reset by the same rst_n.
- Wrap-around: a grant to index N_EXU-1 sets rr_ptr=0.

Decomposition:
- rv32i_types gains:
  - cdb_pkt_t, a packed struct {tag [TAG_W], inst_id [ROB_PTR_W], wdata [DATA_W]}.
  - Localparam CDB_N_EXU, plus index constants EXU_ALU, EXU_MDU, EXU_LSU and EXU_BRU.
- Sub-module rr_arbiter (parameter N):
  - Combinational masked priority encoder producing a one-hot grant and an encoded index from req and ptr.
  - cdb_arbiter owns rr_ptr, the flush handling and the output registers.

Test Plan:
1. Reset, then all exu_req=0 for 5 cycles -> exu_rdy=0000, cdb_vld=0, all payload outputs 0.
2. Only MDU (idx1) reqs tag=6'h0A, inst_id=4'h3, wdata=32'hDEAD_BEEF at cycle t -> exu_rdy=0010 at t; at t+1 cdb_vld=1, tag 0A, id 3, data DEADBEEF, cdb_src=1; at t+2 cdb_vld=0.
3. All four req continuously from reset with distinct payloads -> grants 0,1,2,3,0 on consecutive cycles; cdb_vld high every cycle after the first; each broadcast matches its unit's payload.
4. rr_ptr=3 (after granting idx2); idx0 and idx3 req -> idx3 granted first, then idx0 next cycle (wrap-around).
5. Two units req, flush=1 for one cycle -> both exu_rdy=1 that cycle; next cycle cdb_vld=0; rr_ptr unchanged.
6. rst_n=0 asserted the cycle after a grant to idx2 -> next cycle cdb_vld=0; after release, with all units requesting, idx0 is granted first.
